// File: rtl/flap_game_ctrl_pkg.sv
// Shared game definitions for the player controller and the renderer:
// state encoding, datapath widths, physics constants and screen limits.
package flap_game_ctrl_pkg;

    localparam int HEIGHT_W   = 9;
    localparam int VEL_W      = 5;
    localparam int SCORE_W    = 10;
    localparam int OVER_CNT_W = 7;

    localparam logic [HEIGHT_W-1:0]   START_HEIGHT = 9'd200;
    localparam logic [HEIGHT_W-1:0]   TOP_LIMIT    = 9'd10;
    localparam logic [HEIGHT_W-1:0]   BOTTOM_LIMIT = 9'd420;
    localparam logic signed [VEL_W-1:0] GRAVITY    = 5'sd1;
    localparam logic signed [VEL_W-1:0] FLAP_VEL   = 5'sd7;
    localparam logic signed [VEL_W-1:0] MAX_FALL   = 5'sd8;
    localparam logic [OVER_CNT_W-1:0] OVER_FRAMES  = 7'd120;
    localparam logic [SCORE_W-1:0]    SCORE_MAX    = 10'd999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] cur);
        if (cur >= SCORE_MAX) begin
            return SCORE_MAX;
        end else begin
            return cur + 10'd1;
        end
    endfunction

    // Screen y grows downward, so "too high" is a small height value.
    function automatic logic is_dead(input logic [HEIGHT_W-1:0] h);
        return (h < TOP_LIMIT) || (h > BOTTOM_LIMIT);
    endfunction

endpackage

// File: rtl/flap_game_ctrl_if.sv
// Player-controller bus: frame/button event pulses in, sprite and game status out.
interface flap_game_ctrl_if;
    import flap_game_ctrl_pkg::*;

    logic                tick;
    logic                start;
    logic                flap;
    logic                pass_pipe;
    logic                player_en;
    logic [HEIGHT_W-1:0] height;
    logic [1:0]          game_state;
    logic [SCORE_W-1:0]  score;
    logic                game_over;

    modport master (
        output tick, start, flap, pass_pipe,
        input  player_en, height, game_state, score, game_over
    );

    modport slave (
        input  tick, start, flap, pass_pipe,
        output player_en, height, game_state, score, game_over
    );

endinterface

// File: rtl/flap_game_ctrl_player_physics.sv
// Vertical physics of the player sprite: velocity and height registers,
// flap latch, and the clamped per-tick position update.
module flap_game_ctrl_player_physics
    import flap_game_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                run,
    input  logic                tick,
    input  logic                flap,
    output logic [HEIGHT_W-1:0] height
);

    logic signed [VEL_W-1:0]  vel_r;
    logic signed [VEL_W-1:0]  vel_next_s;
    logic signed [VEL_W:0]    vel_inc_s;
    logic signed [HEIGHT_W:0] sum_s;
    logic [HEIGHT_W-1:0]      height_r;
    logic [HEIGHT_W-1:0]      height_next_s;
    logic                     flap_latch_r;

    // Next velocity (flap or capped gravity) and clamped next height.
    always_comb begin
        vel_inc_s = {vel_r[VEL_W-1], vel_r} + {GRAVITY[VEL_W-1], GRAVITY};
        if (flap_latch_r || flap) begin
            vel_next_s = -FLAP_VEL;
        end else if (vel_inc_s > $signed({MAX_FALL[VEL_W-1], MAX_FALL})) begin
            vel_next_s = MAX_FALL;
        end else begin
            vel_next_s = vel_inc_s[VEL_W-1:0];
        end
        sum_s = $signed({1'b0, height_r})
              + $signed({{(HEIGHT_W+1-VEL_W){vel_next_s[VEL_W-1]}}, vel_next_s});
        // A 10-bit signed sum can never exceed 511, so only the floor needs clamping.
        if (sum_s < 10'sd0) begin
            height_next_s = 9'd0;
        end else begin
            height_next_s = sum_s[HEIGHT_W-1:0];
        end
    end

    // Physics state: parked at the start position, stepped on ticks, or frozen.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            vel_r        <= 5'sd0;
            height_r     <= START_HEIGHT;
            flap_latch_r <= 1'b0;
        end else if (run) begin
            if (tick) begin
                vel_r        <= vel_next_s;
                height_r     <= height_next_s;
                flap_latch_r <= 1'b0;
            end else if (flap) begin
                flap_latch_r <= 1'b1;
            end
        end
    end

    assign height = height_r;

endmodule

// File: rtl/flap_game_ctrl.sv
// Per-frame game sequencer: IDLE/PLAY/OVER state machine, bounds check,
// score counter and game-over timeout around the player physics block.
module flap_game_ctrl
    import flap_game_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    flap_game_ctrl_if.slave  bus
);

    game_state_t             state_r;
    game_state_t             state_next_s;
    logic [OVER_CNT_W-1:0]   over_cnt_r;
    logic [SCORE_W-1:0]      score_r;
    logic                    player_en_r;
    logic                    game_over_r;
    logic                    go_over_s;
    logic                    dead_s;
    logic                    load_s;
    logic                    run_s;
    logic [HEIGHT_W-1:0]     height_s;

    assign dead_s = is_dead(height_s);
    // Park physics throughout IDLE, including the edge that enters it.
    assign load_s = (state_r == ST_IDLE) || (state_next_s == ST_IDLE);
    assign run_s  = (state_r == ST_PLAY) && !dead_s;

    flap_game_ctrl_player_physics u_physics (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .run    (run_s),
        .tick   (bus.tick),
        .flap   (bus.flap),
        .height (height_s)
    );

    // Game state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and game-over event.
    always_comb begin
        state_next_s = state_r;
        go_over_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_PLAY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (dead_s) begin
                    state_next_s = ST_OVER;
                    go_over_s    = 1'b1;
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (over_cnt_r == OVER_FRAMES) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OVER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Frame counter for the OVER screen; idle at zero outside OVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            over_cnt_r <= 7'd0;
        end else if (state_r != ST_OVER) begin
            over_cnt_r <= 7'd0;
        end else if (bus.tick && (over_cnt_r != OVER_FRAMES)) begin
            over_cnt_r <= over_cnt_r + 7'd1;
        end
    end

    // Score: cleared when a game starts, counts cleared obstacles only in PLAY.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_r <= 10'd0;
        end else if ((state_r == ST_IDLE) && bus.start) begin
            score_r <= 10'd0;
        end else if ((state_r == ST_PLAY) && bus.pass_pipe) begin
            score_r <= score_sat_inc(score_r);
        end
    end

    // Registered status outputs aligned with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            player_en_r <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            player_en_r <= (state_next_s == ST_PLAY);
            game_over_r <= go_over_s;
        end
    end

    assign bus.player_en  = player_en_r;
    assign bus.height     = height_s;
    assign bus.game_state = state_r;
    assign bus.score      = score_r;
    assign bus.game_over  = game_over_r;

endmodule

// File: tb/tb_flap_game_ctrl.sv
// Directed self-checking bench for flap_game_ctrl with hand-computed expectations.
module tb_flap_game_ctrl;
    import flap_game_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    flap_game_ctrl_if bus();

    flap_game_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic s, input logic f, input logic p);
        bus.tick = t; bus.start = s; bus.flap = f; bus.pass_pipe = p;
        step();
        bus.tick = 1'b0; bus.start = 1'b0; bus.flap = 1'b0; bus.pass_pipe = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        rst = 1'b0;
        total++; if (bus.game_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.game_state); end
        total++; if (bus.height !== 9'd200) begin bad++; $display("FAIL rst_height got=%0d exp=200", bus.height); end
        total++; if (bus.score !== 10'd0) begin bad++; $display("FAIL rst_score got=%0d exp=0", bus.score); end
        total++; if (bus.player_en !== 1'b0) begin bad++; $display("FAIL rst_player_en got=%0b exp=0", bus.player_en); end
        total++; if (bus.game_over !== 1'b0) begin bad++; $display("FAIL rst_game_over got=%0b exp=0", bus.game_over); end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        total++; if (bus.height !== 9'd200) begin bad++; $display("FAIL idle_ignore_height got=%0d exp=200", bus.height); end
        total++; if (bus.score !== 10'd0) begin bad++; $display("FAIL idle_ignore_score got=%0d exp=0", bus.score); end
    endtask

    task automatic test_free_fall();
        int ff_tab [8] = '{201, 203, 206, 210, 215, 221, 228, 236};
        int exp_h;
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.game_state !== 2'd1) begin bad++; $display("FAIL ff_start_state got=%0d exp=1", bus.game_state); end
        total++; if (bus.player_en !== 1'b1) begin bad++; $display("FAIL ff_player_en got=%0b exp=1", bus.player_en); end
        for (int n = 1; n <= 32; n++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            exp_h = (n <= 8) ? ff_tab[n-1] : 236 + 8 * (n - 8);
            total++; if (bus.height !== 9'(exp_h)) begin bad++; $display("FAIL ff_height tick=%0d got=%0d exp=%0d", n, bus.height, exp_h); end
            total++; if (bus.game_state !== 2'd1) begin bad++; $display("FAIL ff_alive tick=%0d got=%0d exp=1", n, bus.game_state); end
        end
        step();
        total++; if (bus.game_state !== 2'd2) begin bad++; $display("FAIL ff_over_state got=%0d exp=2", bus.game_state); end
        total++; if (bus.game_over !== 1'b1) begin bad++; $display("FAIL ff_game_over got=%0b exp=1", bus.game_over); end
        total++; if (bus.player_en !== 1'b0) begin bad++; $display("FAIL ff_player_en_off got=%0b exp=0", bus.player_en); end
        total++; if (bus.height !== 9'd428) begin bad++; $display("FAIL ff_height_frozen got=%0d exp=428", bus.height); end
        step();
        total++; if (bus.game_over !== 1'b0) begin bad++; $display("FAIL ff_game_over_pulse got=%0b exp=0", bus.game_over); end
    endtask

    task automatic test_over_timeout();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        total++; if (bus.game_state !== 2'd2) begin bad++; $display("FAIL ot_start_ignored got=%0d exp=2", bus.game_state); end
        total++; if (bus.score !== 10'd0) begin bad++; $display("FAIL ot_score_frozen got=%0d exp=0", bus.score); end
        for (int i = 1; i <= 119; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(); step();
        total++; if (bus.game_state !== 2'd2) begin bad++; $display("FAIL ot_119_state got=%0d exp=2", bus.game_state); end
        total++; if (bus.height !== 9'd428) begin bad++; $display("FAIL ot_119_height got=%0d exp=428", bus.height); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step();
        total++; if (bus.game_state !== 2'd0) begin bad++; $display("FAIL ot_120_state got=%0d exp=0", bus.game_state); end
        total++; if (bus.height !== 9'd200) begin bad++; $display("FAIL ot_120_height got=%0d exp=200", bus.height); end
        total++; if (bus.player_en !== 1'b0) begin bad++; $display("FAIL ot_120_player_en got=%0b exp=0", bus.player_en); end
    endtask

    task automatic test_flap();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (bus.height !== 9'd193) begin bad++; $display("FAIL flap_first got=%0d exp=193", bus.height); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.height !== 9'd187) begin bad++; $display("FAIL flap_second got=%0d exp=187", bus.height); end
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 28; n++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            total++; if (bus.height !== 9'(200 - 7 * n)) begin bad++; $display("FAIL flap_climb tick=%0d got=%0d exp=%0d", n, bus.height, 200 - 7 * n); end
            total++; if (bus.game_state !== 2'd1) begin bad++; $display("FAIL flap_alive tick=%0d got=%0d exp=1", n, bus.game_state); end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (bus.game_state !== 2'd2) begin bad++; $display("FAIL flap_top_over got=%0d exp=2", bus.game_state); end
        total++; if (bus.game_over !== 1'b1) begin bad++; $display("FAIL flap_top_game_over got=%0b exp=1", bus.game_over); end
        total++; if (bus.height !== 9'd4) begin bad++; $display("FAIL flap_death_wins got=%0d exp=4", bus.height); end
    endtask

    task automatic test_flap_latch();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step(); step();
        total++; if (bus.height !== 9'd200) begin bad++; $display("FAIL latch_hold got=%0d exp=200", bus.height); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.height !== 9'd193) begin bad++; $display("FAIL latch_apply got=%0d exp=193", bus.height); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.height !== 9'd187) begin bad++; $display("FAIL latch_consumed got=%0d exp=187", bus.height); end
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (bus.height !== 9'd201) begin bad++; $display("FAIL latch_idle_flap got=%0d exp=201", bus.height); end
    endtask

    task automatic test_score();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 1002; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 5 || i == 998 || i == 999 || i == 1002) begin
                total++; if (bus.score !== 10'((i > 999) ? 999 : i)) begin bad++; $display("FAIL score_count n=%0d got=%0d exp=%0d", i, bus.score, (i > 999) ? 999 : i); end
            end
        end
        for (int n = 1; n <= 28; n++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
        end
        step();
        total++; if (bus.game_state !== 2'd2) begin bad++; $display("FAIL score_over_state got=%0d exp=2", bus.game_state); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.score !== 10'd999) begin bad++; $display("FAIL score_over_frozen got=%0d exp=999", bus.score); end
        for (int i = 1; i <= 120; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (bus.game_state !== 2'd0) begin bad++; $display("FAIL score_idle_state got=%0d exp=0", bus.game_state); end
        total++; if (bus.score !== 10'd999) begin bad++; $display("FAIL score_idle_hold got=%0d exp=999", bus.score); end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (bus.score !== 10'd0) begin bad++; $display("FAIL score_start_clear got=%0d exp=0", bus.score); end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
        end
        for (int n = 1; n <= 16; n++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
        end
        total++; if (bus.height !== 9'd300) begin bad++; $display("FAIL mid_height got=%0d exp=300", bus.height); end
        total++; if (bus.score !== 10'd3) begin bad++; $display("FAIL mid_score got=%0d exp=3", bus.score); end
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        total++; if (bus.game_state !== 2'd0) begin bad++; $display("FAIL mid_rst_state got=%0d exp=0", bus.game_state); end
        total++; if (bus.height !== 9'd200) begin bad++; $display("FAIL mid_rst_height got=%0d exp=200", bus.height); end
        total++; if (bus.score !== 10'd0) begin bad++; $display("FAIL mid_rst_score got=%0d exp=0", bus.score); end
        total++; if (bus.player_en !== 1'b0) begin bad++; $display("FAIL mid_rst_player_en got=%0b exp=0", bus.player_en); end
    endtask

    initial begin
        bus.tick = 1'b0; bus.start = 1'b0; bus.flap = 1'b0; bus.pass_pipe = 1'b0;
        rst = 1'b1;
        test_reset();
        test_free_fall();
        test_over_timeout();
        test_flap();
        test_flap_latch();
        test_score();
        test_reset_mid_play();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
